neuron_stim_driver: RTL
=======================

// Module: neuron_stim_driver
// PURPOSE
//   Stimulus/response front end for the tt_um_neuron core: the sending end of its
//   {x1,x0} input byte and the receiving end of its spike output.
//   Queues input-vector pairs via a valid/ready handshake and applies one vector at a time.
//   Holds each vector for HOLD_CYCLES, then samples the spike and returns {vector, spike}
//   on a valid/ready result port.
//   Sits between the host/scan logic and the neuron's ui_in / uo_out[0].
// PARAMETERS
//   DEPTH        4  input FIFO entries; power of 2, >=2
//   HOLD_CYCLES  1  cycles each vector is driven before the spike is sampled; >=1
//   XW           4  width of each operand nibble (x0, x1)
// PORTS
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     input vector valid
//   in_ready   out  1     FIFO can accept (= !full)
//   in_x0      in   XW    operand x0
//   in_x1      in   XW    operand x1
//   nrn_in     out  2*XW  {x1,x0} to neuron ui_in; 0 when no vector is applied
//   nrn_spike  in   1     neuron uo_out[0]
//   res_valid  out  1     result valid
//   res_ready  in   1     result consumer ready
//   res_spike  out  1     sampled spike for res_x
//   res_x      out  2*XW  vector {x1,x0} that produced res_spike
//   busy       out  1     (state != IDLE) || FIFO non-empty
// BEHAVIOUR
//   Reset values: nrn_in=0, res_valid=0, res_spike=0, res_x=0, busy=0, in_ready=1,
//     FIFO empty, state=IDLE, counters 0. Reset is async; it aborts any operation and
//     discards queued and pending results.
//   FIFO: push on in_valid&&in_ready. Pointers are (log2 DEPTH)+1 bits and wrap mod 2*DEPTH.
//     full  = MSBs differ and the low bits are equal.
//     empty = pointers equal.
//     When full, in_ready=0 even if a pop occurs in the same cycle. Simultaneous push and
//     pop when not full is legal; occupancy is unchanged.
//   FSM IDLE -> DRIVE -> REPORT -> IDLE:
//     IDLE:   if !empty, pop the head into nrn_in, load hold_cnt=HOLD_CYCLES-1, go to DRIVE.
//             If empty, stay; nrn_in=0.
//     DRIVE:  nrn_in is held stable. If hold_cnt!=0, decrement. If hold_cnt==0, capture
//             res_spike<=nrn_spike and res_x<=nrn_in, set res_valid=1, go to REPORT.
//     REPORT: res_valid, res_spike and res_x are held stable until res_ready.
//             On res_valid&&res_ready: res_valid<=0, nrn_in<=0, go to IDLE.
//   Latency (empty FIFO, IDLE, res_ready=1): push accepted at edge E0; nrn_in valid after
//     edge E1; spike sampled and res_valid=1 after edge E(1+HOLD_CYCLES).
//     Throughput is one vector per HOLD_CYCLES+2 cycles.
//   The neuron is treated as combinational: the spike must settle within one cycle of nrn_in.
//   res_ready while res_valid=0 is ignored. Results leave in push order; none are dropped.
//   nrn_spike is ignored outside the sample edge.
// CONFIGURATION
//   NEURON_STIM_CNT_EN defined:
//     adds port spike_cnt out 8: count of completed result handshakes with res_spike=1.
//     Saturates at 255; reset to 0.
//   NEURON_STIM_CNT_EN undefined: port and counter are absent; all other behaviour identical.
// TESTING (bench neuron model: spike = (x0+x1) != 0, combinational)
//   1. rst_n=0 mid-stream -> nrn_in=0, res_valid=0, in_ready=1, busy=0 immediately (no clk edge).
//   2. HOLD=1, push x0=1,x1=1 -> nrn_in=8'h11 after E1; after E2 res_valid=1, res_spike=1,
//      res_x=8'h11.
//   3. Push x0=0,x1=0 -> res_spike=0, res_x=8'h00; nrn_in returns to 0 after the handshake.
//   4. res_ready=0, push 11,22,44,00,33 back-to-back -> in_ready=0 once 4 are queued.
//      Release res_ready -> results 11/1, 22/1, 44/1, 00/0, 33/1 in order.
//   5. HOLD_CYCLES=3 -> nrn_in stable 3 cycles; a spike pulsed only before the last DRIVE
//      cycle is not captured.
//   6. NEURON_STIM_CNT_EN: 3 spiking + 1 non-spiking result -> spike_cnt=3;
//      300 spiking -> spike_cnt=255.

Source files
------------

// File: rtl/neuron_stim_driver.sv
`default_nettype none
// ============================================================================
// Module   : neuron_stim_driver
// Purpose  : Queues {x1,x0} vectors, drives them onto the neuron input, samples
//            its spike and returns {vector, spike} on a valid/ready port.
//            Optional NEURON_STIM_CNT_EN adds a saturating spike counter.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_stim_driver #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int XW          = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XW-1:0]   in_x0,
  input  logic [XW-1:0]   in_x1,
  output logic [2*XW-1:0] nrn_in,
  input  logic            nrn_spike,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_spike,
  output logic [2*XW-1:0] res_x,
  output logic            busy
`ifdef NEURON_STIM_CNT_EN
  ,
  output logic [7:0]      spike_cnt
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_HOLD_LOAD = c_CW'(HOLD_CYCLES - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE   = {{(c_CW-1){1'b0}}, 1'b1};
  localparam logic [c_AW:0]   c_PTR_ONE   = {{c_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t              r_state;
  logic [2*XW-1:0]     r_mem [DEPTH];
  logic [c_AW:0]       r_wr_ptr;
  logic [c_AW:0]       r_rd_ptr;
  logic [c_CW-1:0]     r_hold_cnt;
  logic [2*XW-1:0]     r_nrn_in;
  logic                r_res_valid;
  logic                r_res_spike;
  logic [2*XW-1:0]     r_res_x;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  assign in_ready  = !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign nrn_in    = r_nrn_in;
  assign res_valid = r_res_valid;
  assign res_spike = r_res_spike;
  assign res_x     = r_res_x;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {in_x1, in_x0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_hold_cnt  <= '0;
      r_nrn_in    <= '0;
      r_res_valid <= 1'b0;
      r_res_spike <= 1'b0;
      r_res_x     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_nrn_in   <= r_mem[r_rd_ptr[c_AW-1:0]];
            r_hold_cnt <= c_HOLD_LOAD;
            r_state    <= S_DRIVE;
          end else begin
            r_nrn_in <= '0;
          end
        end
        S_DRIVE: begin
          if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - c_CNT_ONE;
          end else begin
            // Last hold cycle: the neuron has settled on r_nrn_in.
            r_res_spike <= nrn_spike;
            r_res_x     <= r_nrn_in;
            r_res_valid <= 1'b1;
            r_state     <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_nrn_in    <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef NEURON_STIM_CNT_EN
  logic [7:0] r_spike_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_cnt <= 8'd0;
    end else if (r_res_valid && res_ready && r_res_spike && (r_spike_cnt != 8'hFF)) begin
      r_spike_cnt <= r_spike_cnt + 8'd1;
    end
  end

  assign spike_cnt = r_spike_cnt;
`endif

endmodule
`default_nettype wire
